// File: rtl/mul_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_arb_pkg
// Desc     : Shared FSM state type and ID-width helper for mul_share_arbiter.
// Revision : 1.0
// ============================================================================
package mul_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_RESP
   } mul_arb_state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// Module   : multiplier
// Desc     : Combinational unsigned multiplier, full 2*WIDTH product.
// Revision : 1.0
// ============================================================================
module multiplier #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product
);

   assign product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter
// Desc     : Round-robin sharing of one multiplier among NREQ requesters,
//            one operation in flight, ID-tagged response channel.
// Revision : 1.0
// ============================================================================
module mul_share_arbiter
   import mul_arb_pkg::*;
#(
   parameter int  WIDTH = 8,
   parameter int  NREQ  = 4,
   localparam int IDW   = id_width(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [2*WIDTH-1:0]    rsp_product,
   output logic                  busy
);

   mul_arb_state_t     r_state;
   logic [IDW-1:0]     r_rr_ptr;
   logic [IDW-1:0]     r_id_q;
   logic [IDW-1:0]     r_rsp_id;
   logic [WIDTH-1:0]   r_op_a;
   logic [WIDTH-1:0]   r_op_b;
   logic [2*WIDTH-1:0] r_rsp_product;
   logic               r_rsp_valid;

   logic [IDW-1:0]     w_grant;
   logic [IDW-1:0]     w_ptr_next;
   logic [WIDTH-1:0]   w_sel_a;
   logic [WIDTH-1:0]   w_sel_b;
   logic [2*WIDTH-1:0] w_product;
   logic               w_any;

   // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [IDW-1:0]  ptr);
      logic [2*NREQ-1:0] rot;
      int                first;
      int                sum;
      rot   = {v, v} >> ptr;
      first = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) first = k;
      end
      sum = int'(ptr) + first;
      if (sum >= NREQ) sum = sum - NREQ;
      return IDW'(sum);
   endfunction

   assign w_any      = |req_valid;
   assign w_grant    = rr_pick(req_valid, r_rr_ptr);
   assign w_ptr_next = (r_id_q == IDW'(NREQ - 1)) ? '0 : r_id_q + 1'b1;

   always_comb begin
      w_sel_a   = '0;
      w_sel_b   = '0;
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant == IDW'(i)) begin
            w_sel_a = req_a[i*WIDTH +: WIDTH];
            w_sel_b = req_b[i*WIDTH +: WIDTH];
         end
         req_ready[i] = rst_n && (r_state == ST_IDLE) && req_valid[i] && (w_grant == IDW'(i));
      end
   end

   multiplier #(.WIDTH(WIDTH)) u_multiplier (
      .a       (r_op_a),
      .b       (r_op_b),
      .product (w_product)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_rr_ptr      <= '0;
         r_id_q        <= '0;
         r_op_a        <= '0;
         r_op_b        <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_id      <= '0;
         r_rsp_product <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_op_a  <= w_sel_a;
                  r_op_b  <= w_sel_b;
                  r_id_q  <= w_grant;
                  r_state <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_rsp_product <= w_product;
               r_rsp_id      <= r_id_q;
               r_rsp_valid   <= 1'b1;
               r_state       <= ST_RESP;
            end
            ST_RESP: begin
               // Pointer only moves on completion so idle cycles never skip anyone.
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rr_ptr    <= w_ptr_next;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rsp_valid   = r_rsp_valid;
   assign rsp_id      = r_rsp_id;
   assign rsp_product = r_rsp_product;
   assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mul_share_arbiter
// Desc     : Directed self-checking bench for mul_share_arbiter (WIDTH=8, NREQ=4).
// Revision : 1.0
// ============================================================================
module tb_mul_share_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [2*WIDTH-1:0]    rsp_product;
   logic                  busy;

   logic [WIDTH-1:0]      va [NREQ];
   logic [WIDTH-1:0]      vb [NREQ];
   logic [15:0]           exp3 [NREQ];

   int n_checks = 0;
   int n_fail   = 0;

   mul_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*WIDTH +: WIDTH] = va[i];
         req_b[i*WIDTH +: WIDTH] = vb[i];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input int budget, output int n);
      n = 0;
      while (!rsp_valid && n < budget) begin
         step();
         n++;
      end
      if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      int n;
      logic [3:0] e_rdy;
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         va[i] = '0;
         vb[i] = '0;
      end
      exp3[0] = 16'd12;
      exp3[1] = 16'd30;
      exp3[2] = 16'd143;
      exp3[3] = 16'd50000;

      // Reset state
      repeat (2) step();
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_product", 32'(rsp_product), 32'd0);
      rst_n = 1'b1;
      step();

      // Single request on requester 1
      va[1] = 8'd7; vb[1] = 8'd9; req_valid = 4'b0010;
      #1;
      check("t1_ready", 32'(req_ready), 32'b0010);
      step();
      req_valid = '0;
      #1;
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_calc_ready", 32'(req_ready), 32'd0);
      check("t1_calc_valid", 32'(rsp_valid), 32'd0);
      wait_rsp(5, n);
      check("t1_latency", 32'(n), 32'd1);
      check("t1_id", 32'(rsp_id), 32'd1);
      check("t1_product", 32'(rsp_product), 32'd63);
      finish_rsp();
      check("t1_done_valid", 32'(rsp_valid), 32'd0);
      check("t1_done_busy", 32'(busy), 32'd0);

      // Full-scale operands on requester 3
      va[3] = 8'd255; vb[3] = 8'd255; req_valid = 4'b1000;
      #1;
      check("t2_ready", 32'(req_ready), 32'b1000);
      step();
      req_valid = '0;
      wait_rsp(5, n);
      check("t2_id", 32'(rsp_id), 32'd3);
      check("t2_product", 32'(rsp_product), 32'hFE01);
      finish_rsp();

      // All requesters continuously valid, consumer always ready
      va[0] = 8'd3;  vb[0] = 8'd4;
      va[1] = 8'd5;  vb[1] = 8'd6;
      va[2] = 8'd11; vb[2] = 8'd13;
      va[3] = 8'd200; vb[3] = 8'd250;
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int k = 0; k < 15; k++) begin
         #1;
         e_rdy = (k % 3 == 0) ? (4'b0001 << ((k / 3) % 4)) : 4'b0000;
         check($sformatf("t3_ready_c%0d", k), 32'(req_ready), 32'(e_rdy));
         check($sformatf("t3_valid_c%0d", k), 32'(rsp_valid), (k % 3 == 2) ? 32'd1 : 32'd0);
         if (k % 3 == 2) begin
            check($sformatf("t3_id_c%0d", k), 32'(rsp_id), 32'((k / 3) % 4));
            check($sformatf("t3_product_c%0d", k), 32'(rsp_product), 32'(exp3[(k / 3) % 4]));
         end
         if (k == 14) req_valid = '0;
         step();
      end
      rsp_ready = 1'b0;

      // Response stall with operand churn (rr_ptr=1, requester 2)
      va[2] = 8'd18; vb[2] = 8'd20; req_valid = 4'b0100;
      #1;
      check("t4_ready", 32'(req_ready), 32'b0100);
      step();
      req_valid = '0;
      wait_rsp(5, n);
      for (int s = 0; s < 10; s++) begin
         va[2] = va[2] + 8'(s + 1);
         req_valid = 4'b1111;
         #1;
         check($sformatf("t4_stall_product_%0d", s), 32'(rsp_product), 32'd360);
         check($sformatf("t4_stall_id_%0d", s), 32'(rsp_id), 32'd2);
         check($sformatf("t4_stall_ready_%0d", s), 32'(req_ready), 32'd0);
         check($sformatf("t4_stall_valid_%0d", s), 32'(rsp_valid), 32'd1);
         step();
      end

      // Completion with a pending request: no grant in the RESP cycle, then wrap to 0
      va[0] = 8'd0; vb[0] = 8'd200; req_valid = 4'b0001; rsp_ready = 1'b1;
      #1;
      check("t5_resp_no_grant", 32'(req_ready), 32'd0);
      step();
      rsp_ready = 1'b0;
      #1;
      check("t5_wrap_ready", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      wait_rsp(5, n);
      check("t5_id", 32'(rsp_id), 32'd0);
      check("t5_product", 32'(rsp_product), 32'd0);
      finish_rsp();

      // Reset during CALC discards the operation and restores rr_ptr=0
      va[1] = 8'd9; vb[1] = 8'd9; req_valid = 4'b0010;
      #1;
      check("t6_ready", 32'(req_ready), 32'b0010);
      step();
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_valid", 32'(rsp_valid), 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("t6_no_rsp_%0d", c), 32'(rsp_valid), 32'd0);
      end
      va[0] = 8'd13; vb[0] = 8'd11; va[3] = 8'd2; vb[3] = 8'd3;
      req_valid = 4'b1001;
      #1;
      check("t6_first_grant", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      wait_rsp(5, n);
      check("t6_id", 32'(rsp_id), 32'd0);
      check("t6_product", 32'(rsp_product), 32'd143);
      finish_rsp();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
